// File: rtl/weight_tile_loader_if.sv
// Memory read port and weight-tile handshake shared by the tile loader
// (master) and the memory / GEMV side (slave).
interface weight_tile_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_SIZE  = 32,
    parameter int MEM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 24
);
    logic                         mem_req;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [MEM_WIDTH-1:0]         mem_rdata;
    logic                         mem_rvalid;
    logic signed [DATA_WIDTH-1:0] w_tile_row_out [0:TILE_SIZE-1];
    logic                         w_valid;
    logic                         w_ready;

    modport master (
        output mem_req, mem_addr, w_tile_row_out, w_valid,
        input  mem_rdata, mem_rvalid, w_ready
    );

    modport slave (
        input  mem_req, mem_addr, w_tile_row_out, w_valid,
        output mem_rdata, mem_rvalid, w_ready
    );
endinterface

// File: rtl/weight_tile_loader.sv
// Fetches a row-major weight matrix word by word and presents it to the GEMV
// stage one zero-padded TILE_SIZE-lane tile at a time.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; inputs latched on start
// S_REQ     | one-cycle memory read request
// S_WAIT    | waiting for mem_rvalid, word stored into the tile buffer
// S_PRESENT | tile valid, held until accepted
// S_EMPTY   | zero-sized matrix, one busy cycle before completion
// S_DONE    | done pulse, busy cleared
module weight_tile_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int TILE_SIZE   = 32,
    parameter int MEM_WIDTH   = 64,
    parameter int ADDR_WIDTH  = 24,
    parameter int MAX_ROWS    = 1024,
    parameter int MAX_COLUMNS = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [$clog2(MAX_ROWS):0]    rows,
    input  logic [$clog2(MAX_COLUMNS):0] cols,
    output logic                         busy,
    output logic                         done,
    weight_tile_loader_if.master         bus
);
    localparam int BPW     = MEM_WIDTH / DATA_WIDTH;
    localparam int WPT     = TILE_SIZE / BPW;
    localparam int LOG_BPW = $clog2(BPW);
    localparam int RW      = $clog2(MAX_ROWS) + 1;
    localparam int CW      = $clog2(MAX_COLUMNS) + 1;
    localparam int KW      = (WPT > 1) ? $clog2(WPT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_PRESENT,
        S_EMPTY,
        S_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_WIDTH-1:0] row_base;
    logic [RW-1:0]         rows_left;
    logic [CW-1:0]         cols_r;
    logic [CW-1:0]         cols_left;
    logic [CW-1:0]         wpr_r;
    logic [CW-1:0]         words_left;
    logic [CW-1:0]         word_off;
    logic [KW-1:0]         word_k;

    logic [CW:0]           cols_round;
    logic [CW-1:0]         wpr_in;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  last_word;
    logic                  row_end;
    logic                  last_tile;

    logic                  mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic                  w_valid_d;
    logic                  busy_d;
    logic                  done_d;

    // Words per row: each row is padded up to a whole memory word.
    assign cols_round = {1'b0, cols} + (CW+1)'(BPW - 1);
    assign wpr_in     = CW'(cols_round >> LOG_BPW);

    assign word_addr  = row_base + ADDR_WIDTH'(word_off);
    assign last_word  = (words_left == CW'(1)) || (word_k == KW'(WPT - 1));
    assign row_end    = (words_left == '0);
    assign last_tile  = row_end && (rows_left == RW'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (rows == '0 || cols == '0) ? S_EMPTY : S_REQ;
                end
            end
            S_REQ:     next_state = S_WAIT;
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    next_state = last_word ? S_PRESENT : S_REQ;
                end
            end
            S_PRESENT: begin
                if (bus.w_ready) begin
                    next_state = last_tile ? S_DONE : S_REQ;
                end
            end
            S_EMPTY:   next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        mem_addr_d = bus.mem_addr;
        case (state)
            S_IDLE: begin
                if (start) mem_addr_d = base_addr;
            end
            S_WAIT: begin
                if (bus.mem_rvalid && !last_word) mem_addr_d = word_addr + ADDR_WIDTH'(1);
            end
            S_PRESENT: begin
                if (bus.w_ready && !last_tile) begin
                    mem_addr_d = row_end ? (row_base + ADDR_WIDTH'(wpr_r)) : word_addr;
                end
            end
            default: ;
        endcase
        mem_req_d = (next_state == S_REQ);
        w_valid_d = (next_state == S_PRESENT);
        done_d    = (next_state == S_DONE);
        busy_d    = (next_state == S_REQ) || (next_state == S_WAIT) ||
                    (next_state == S_PRESENT) || (next_state == S_EMPTY);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.w_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            bus.mem_req  <= mem_req_d;
            bus.mem_addr <= mem_addr_d;
            bus.w_valid  <= w_valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_base   <= '0;
            rows_left  <= '0;
            cols_r     <= '0;
            cols_left  <= '0;
            wpr_r      <= '0;
            words_left <= '0;
            word_off   <= '0;
            word_k     <= '0;
            for (int l = 0; l < TILE_SIZE; l++) bus.w_tile_row_out[l] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row_base   <= base_addr;
                        rows_left  <= rows;
                        cols_r     <= cols;
                        cols_left  <= cols;
                        wpr_r      <= wpr_in;
                        words_left <= wpr_in;
                        word_off   <= '0;
                        word_k     <= '0;
                        for (int l = 0; l < TILE_SIZE; l++) bus.w_tile_row_out[l] <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        // Bytes past the row's last column are dropped, so a
                        // partial final word never leaks stale data into lanes.
                        for (int l = 0; l < TILE_SIZE; l++) begin
                            if (word_k == KW'(l / BPW)) begin
                                bus.w_tile_row_out[l] <= (CW'(l) < cols_left) ?
                                    bus.mem_rdata[(l % BPW)*DATA_WIDTH +: DATA_WIDTH] : '0;
                            end
                        end
                        words_left <= words_left - CW'(1);
                        word_off   <= word_off + CW'(1);
                        word_k     <= last_word ? '0 : word_k + KW'(1);
                    end
                end
                S_PRESENT: begin
                    if (bus.w_ready) begin
                        for (int l = 0; l < TILE_SIZE; l++) bus.w_tile_row_out[l] <= '0;
                        word_k <= '0;
                        if (row_end) begin
                            row_base   <= row_base + ADDR_WIDTH'(wpr_r);
                            rows_left  <= rows_left - RW'(1);
                            word_off   <= '0;
                            words_left <= wpr_r;
                            cols_left  <= cols_r;
                        end else begin
                            cols_left  <= cols_left - CW'(TILE_SIZE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader: latency-programmable memory model,
// handshake monitor and a reference tile/address model built from the matrix shape.
module tb_weight_tile_loader;
    localparam int DW  = 8;
    localparam int TS  = 32;
    localparam int MW  = 64;
    localparam int AW  = 24;
    localparam int BPW = MW / DW;
    localparam int WPT = TS / BPW;

    typedef logic [255:0] val_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [10:0]   rows = '0;
    logic [10:0]   cols = '0;
    logic          busy;
    logic          done;

    weight_tile_loader_if #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

    weight_tile_loader #(
        .DATA_WIDTH(DW), .TILE_SIZE(TS), .MEM_WIDTH(MW), .ADDR_WIDTH(AW),
        .MAX_ROWS(1024), .MAX_COLUMNS(1024)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .rows(rows), .cols(cols), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input val_t act, input val_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory model
    bit          mem_en  = 1'b1;
    bit          ff_mode = 1'b0;
    int          lat     = 1;
    bit          pend    = 1'b0;
    int          pcnt    = 0;
    int          paddr   = 0;

    function automatic logic [7:0] byte_at(input int a, input int b);
        return ff_mode ? 8'hFF : {a[4:0], b[2:0]};
    endfunction

    function automatic logic [MW-1:0] word_at(input int a);
        logic [MW-1:0] w;
        for (int b = 0; b < BPW; b++) w[b*8 +: 8] = byte_at(a, b);
        return w;
    endfunction

    always @(negedge clk) begin
        if (mem_en) begin
            bus.mem_rvalid = 1'b0;
            if (pend) begin
                if (pcnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = word_at(paddr);
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            if (bus.mem_req) begin
                pend  = 1'b1;
                pcnt  = lat - 1;
                paddr = int'(bus.mem_addr);
            end
        end else begin
            pend = 1'b0;
        end
    end

    // Monitor
    logic [AW-1:0]    req_q[$];
    int               req_cyc_q[$];
    logic [TS*DW-1:0] tile_q[$];
    int               hs_cyc_q[$];
    int               done_q[$];
    int               vrise_q[$];
    bit               prev_v = 1'b0;
    int               st_cyc = 0;

    function automatic logic [TS*DW-1:0] pack_tile();
        logic [TS*DW-1:0] p;
        for (int l = 0; l < TS; l++) p[l*8 +: 8] = bus.w_tile_row_out[l];
        return p;
    endfunction

    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_q.push_back(bus.mem_addr);
            req_cyc_q.push_back(cyc);
        end
        if (bus.w_valid && !prev_v) vrise_q.push_back(cyc);
        prev_v = bus.w_valid;
        if (bus.w_valid && bus.w_ready) begin
            tile_q.push_back(pack_tile());
            hs_cyc_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        req_q.delete(); req_cyc_q.delete(); tile_q.delete();
        hs_cyc_q.delete(); done_q.delete(); vrise_q.delete();
    endtask

    task automatic pulse_start(input int b, input int r, input int c);
        base_addr = AW'(b);
        rows      = 11'(r);
        cols      = 11'(c);
        start     = 1'b1;
        st_cyc    = cyc;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int budget = 3000;
        while (done_q.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();
    endtask

    task automatic go(input int b, input int r, input int c);
        clear_mon();
        pulse_start(b, r, c);
        wait_done();
    endtask

    // Reference: addresses and tile contents derived from the matrix shape.
    task automatic verify(input string tag, input int b, input int nr, input int nc);
        int wpr, tpr, nw, ai, ti, a, col;
        logic [TS*DW-1:0] exp_t;
        wpr = (nc + BPW - 1) / BPW;
        tpr = (nc + TS - 1) / TS;
        check({tag, "_nreq"},  val_t'(req_q.size()),  val_t'(nr * wpr));
        check({tag, "_ntile"}, val_t'(tile_q.size()), val_t'(nr * tpr));
        ai = 0;
        ti = 0;
        for (int r = 0; r < nr; r++) begin
            for (int t = 0; t < tpr; t++) begin
                nw = (wpr - t*WPT < WPT) ? (wpr - t*WPT) : WPT;
                exp_t = '0;
                for (int k = 0; k < nw; k++) begin
                    a = b + r*wpr + t*WPT + k;
                    if (ai < req_q.size())
                        check($sformatf("%s_addr%0d", tag, ai), val_t'(req_q[ai]), val_t'(a));
                    ai++;
                    for (int y = 0; y < BPW; y++) begin
                        col = t*TS + k*BPW + y;
                        if (col < nc) exp_t[(k*BPW + y)*8 +: 8] = byte_at(a, y);
                    end
                end
                if (ti < tile_q.size())
                    check($sformatf("%s_tile%0d", tag, ti), val_t'(tile_q[ti]), val_t'(exp_t));
                ti++;
            end
        end
        check({tag, "_ndone"}, val_t'(done_q.size()), val_t'(1));
        if (done_q.size() > 0 && hs_cyc_q.size() > 0)
            check({tag, "_done_cyc"}, val_t'(done_q[0]), val_t'(hs_cyc_q[hs_cyc_q.size()-1] + 1));
        check({tag, "_busy_end"}, val_t'(busy), val_t'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int budget, viol, nreq;
        logic [TS*DW-1:0] snap;

        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.w_ready    = 1'b1;

        repeat (3) tick();
        check("rst_mem_req",  val_t'(bus.mem_req),  val_t'(0));
        check("rst_mem_addr", val_t'(bus.mem_addr), val_t'(0));
        check("rst_w_valid",  val_t'(bus.w_valid),  val_t'(0));
        check("rst_busy",     val_t'(busy),         val_t'(0));
        check("rst_done",     val_t'(done),         val_t'(0));
        check("rst_lanes",    val_t'(pack_tile()),  val_t'(0));
        reset_n = 1'b1;
        tick();

        // Basic fetch, latency 1
        lat = 1;
        go(32'h100, 2, 32);
        verify("basic", 32'h100, 2, 32);
        if (req_cyc_q.size() > 0)
            check("basic_first_req", val_t'(req_cyc_q[0]), val_t'(st_cyc + 1));
        if (vrise_q.size() > 0)
            check("basic_valid_cyc", val_t'(vrise_q[0]), val_t'(st_cyc + 9));
        if (req_cyc_q.size() > 4 && hs_cyc_q.size() > 0)
            check("basic_req_after_hs", val_t'(req_cyc_q[4]), val_t'(hs_cyc_q[0] + 1));

        // Partial tile, latency 3
        lat = 3;
        go(32'h100, 2, 40);
        verify("ptile", 32'h100, 2, 40);

        // Backpressure
        lat = 2;
        bus.w_ready = 1'b0;
        clear_mon();
        pulse_start(32'h500, 1, 64);
        budget = 200;
        while (!bus.w_valid && budget > 0) begin
            tick();
            budget--;
        end
        check("bp_valid_seen", val_t'(bus.w_valid), val_t'(1));
        snap = pack_tile();
        nreq = req_q.size();
        viol = 0;
        repeat (10) begin
            tick();
            if (!bus.w_valid || pack_tile() !== snap) viol++;
        end
        check("bp_stable", val_t'(viol), val_t'(0));
        check("bp_noreq",  val_t'(req_q.size()), val_t'(nreq));
        bus.w_ready = 1'b1;
        wait_done();
        verify("bp", 32'h500, 1, 64);
        if (tile_q.size() > 0)
            check("bp_tile_hold", val_t'(tile_q[0]), val_t'(snap));
        if (req_cyc_q.size() > 4 && hs_cyc_q.size() > 0)
            check("bp_next_req", val_t'(req_cyc_q[4]), val_t'(hs_cyc_q[0] + 1));

        // Partial word with all-ones memory
        lat = 1;
        ff_mode = 1'b1;
        go(32'h10, 1, 3);
        verify("pword", 32'h10, 1, 3);
        if (tile_q.size() > 0)
            check("pword_lanes", val_t'(tile_q[0]), val_t'(256'hFFFFFF));
        ff_mode = 1'b0;

        // Degenerate starts
        go(32'h20, 0, 16);
        verify("degen_r0", 32'h20, 0, 16);
        if (done_q.size() > 0)
            check("degen_done_cyc", val_t'(done_q[0]), val_t'(st_cyc + 2));
        check("degen_no_valid", val_t'(vrise_q.size()), val_t'(0));
        go(32'h20, 3, 0);
        verify("degen_c0", 32'h20, 3, 0);

        // Reset mid-WAIT, then a late rvalid
        mem_en = 1'b0;
        bus.mem_rvalid = 1'b0;
        clear_mon();
        pulse_start(32'h300, 1, 32);
        budget = 50;
        while (req_q.size() == 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("rstw_req_seen", val_t'(req_q.size()), val_t'(1));
        repeat (2) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = '1;
        clear_mon();
        tick();
        bus.mem_rvalid = 1'b0;
        viol = 0;
        repeat (8) begin
            tick();
            if (bus.mem_req || bus.w_valid || done || busy || pack_tile() != '0) viol++;
        end
        check("rstw_quiet",    val_t'(viol),           val_t'(0));
        check("rstw_mem_addr", val_t'(bus.mem_addr),   val_t'(0));
        check("rstw_no_tile",  val_t'(tile_q.size()),  val_t'(0));
        check("rstw_no_done",  val_t'(done_q.size()),  val_t'(0));
        mem_en = 1'b1;
        go(32'h40, 1, 16);
        verify("rstw_fresh", 32'h40, 1, 16);

        // Start while busy is ignored
        clear_mon();
        pulse_start(32'h200, 2, 32);
        repeat (5) tick();
        pulse_start(32'h800, 1, 8);
        wait_done();
        verify("busy_start", 32'h200, 2, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
